mem_arbiter: RTL and testbench

- Arbitrates one single-port unified memory between the fetch stage (instruction port) and the memory stage (data port) of the 5-stage pipeline.
- Sequences each access: latches the command, issues it, waits a fixed memory latency, then returns the read data and a one-cycle valid pulse.
- Produces stall_f / stall_m, which the hazard logic ORs into the pipeline-register enables.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/floprc.sv | 17 +
 rtl/lat_cnt.sv | 22 ++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side and memory-side signals of mem_arbiter.
// slave = arbiter view, master = pipeline + memory view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;

  logic          stall_f;
  logic          stall_m;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid, stall_f, stall_m,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid, stall_f, stall_m,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/floprc.sv
// Flop with synchronous active-low reset and synchronous clear.
module floprc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst || clr) q <= '0;
    else             q <= d;
  end

endmodule

// File: rtl/lat_cnt.sv
// Loadable down-counter timing the memory latency; done marks cnt==1.
module lat_cnt
  import mem_arb_pkg::*;
(
  input  logic             clka,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clka) begin
    if (!rst)             cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and data ports of the pipeline.
// Optional round-robin arbitration when MEM_ARB_RR_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input logic          clka,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int CMD_W = 1 + AW + DW;

  state_e           state, state_d;
  gnt_e             gnt_sel;
  logic             gnt_vld;
  logic             arb_point;
  logic             d_cand, i_cand;
  logic             done;
  logic             mem_en_q;

  logic             we_new;
  logic [AW-1:0]    addr_new;
  logic [DW-1:0]    wdata_new;
  logic [CMD_W-1:0] cmd_d, cmd_q;
  logic             cmd_we;
  logic [AW-1:0]    cmd_addr;
  logic [DW-1:0]    cmd_wdata;

`ifdef MEM_ARB_RR_EN
  gnt_e             last_gnt;
`endif

  always_ff @(posedge clka) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // The side just served is masked out at its own completion cycle.
  always_comb begin
    d_cand    = bus.d_req  && (state != BUSY_D);
    i_cand    = bus.if_req && (state != BUSY_I);
    arb_point = (state == IDLE) || done;
    gnt_vld   = 1'b0;
    gnt_sel   = GNT_D;
    state_d   = state;
    if (arb_point) begin
      gnt_vld = d_cand || i_cand;
`ifdef MEM_ARB_RR_EN
      if (d_cand && i_cand) gnt_sel = (last_gnt == GNT_D) ? GNT_I : GNT_D;
      else                  gnt_sel = d_cand ? GNT_D : GNT_I;
`else
      gnt_sel = d_cand ? GNT_D : GNT_I;
`endif
      if (!gnt_vld)               state_d = IDLE;
      else if (gnt_sel == GNT_D)  state_d = BUSY_D;
      else                        state_d = BUSY_I;
    end
  end

  always_comb begin
    bus.if_valid = (state == BUSY_I) && done;
    bus.d_valid  = (state == BUSY_D) && done;
    bus.if_rdata = '0;
    bus.d_rdata  = '0;
    if (bus.if_valid)           bus.if_rdata = bus.mem_rdata;
    if (bus.d_valid && !cmd_we) bus.d_rdata  = bus.mem_rdata;
    // Stalls are forced low while reset is asserted so every output reads 0.
    bus.stall_f = rst && bus.if_req && !bus.if_valid;
    bus.stall_m = rst && bus.d_req  && !bus.d_valid;
  end

  always_ff @(posedge clka) begin
    if (!rst) mem_en_q <= 1'b0;
    else      mem_en_q <= gnt_vld;
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clka) begin
    if (!rst)         last_gnt <= GNT_D;
    else if (gnt_vld) last_gnt <= gnt_sel;
  end
`endif

  always_comb begin
    if (gnt_sel == GNT_D) begin
      we_new    = bus.d_we;
      addr_new  = bus.d_addr;
      wdata_new = bus.d_we ? bus.d_wdata : '0;
    end else begin
      we_new    = 1'b0;
      addr_new  = bus.if_addr;
      wdata_new = '0;
    end
    cmd_d = gnt_vld ? {we_new, addr_new, wdata_new} : cmd_q;
  end

  floprc #(.WIDTH(CMD_W)) u_cmd (
    .clk (clka),
    .rst (rst),
    .clr (1'b0),
    .d   (cmd_d),
    .q   (cmd_q)
  );

  assign {cmd_we, cmd_addr, cmd_wdata} = cmd_q;

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = cmd_we;
  assign bus.mem_addr  = cmd_addr;
  assign bus.mem_wdata = cmd_wdata;

  // Counter loads during the mem_en cycle so cnt==1 lands MEM_LAT cycles later.
  lat_cnt u_lat (
    .clka     (clka),
    .rst      (rst),
    .load     (mem_en_q),
    .load_val (CNT_W'(MEM_LAT)),
    .done     (done)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, scoreboard, memory model.
module tb_mem_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int MEM_LAT = 2;

  logic clka = 1'b0;
  logic rst  = 1'b0;
  always #5 clka = ~clka;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
    .clka (clka),
    .rst  (rst),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { bit is_d; logic [DW-1:0] rdata; } sb_t;
  typedef struct { int unsigned due; logic [DW-1:0] data; } resp_t;
  typedef struct {
    bit            is_d;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } vec_t;

  sb_t           sb_q[$];
  resp_t         resp_q[$];
  logic [DW-1:0] mem_model [0:255];
  int unsigned   ncount = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clka);
    #1;
  endtask

  task automatic sb_push(input bit is_d, input logic [DW-1:0] rdata);
    sb_t e;
    e.is_d  = is_d;
    e.rdata = rdata;
    sb_q.push_back(e);
  endtask

  task automatic drive_d(input bit req, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bus.d_req   = req;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
  endtask

  task automatic drive_i(input bit req, input logic [AW-1:0] addr);
    bus.if_req  = req;
    bus.if_addr = addr;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_ctl"}, {bus.mem_en, bus.mem_we, bus.if_valid, bus.d_valid, bus.stall_f, bus.stall_m}, '0);
    check({nm, "_addr"}, bus.mem_addr, '0);
    check({nm, "_wdata"}, bus.mem_wdata, '0);
  endtask

  // Memory with MEM_LAT read latency; junk on mem_rdata when no response is due.
  always begin : mem_model_proc
    resp_t r;
    @(negedge clka);
    ncount++;
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we === 1'b1) mem_model[bus.mem_addr[9:2]] = bus.mem_wdata;
      r.due  = ncount + MEM_LAT;
      r.data = mem_model[bus.mem_addr[9:2]];
      resp_q.push_back(r);
    end
    @(posedge clka);
    #1;
    if (resp_q.size() > 0 && resp_q[0].due == ncount + 1) begin
      bus.mem_rdata = resp_q[0].data;
      void'(resp_q.pop_front());
    end else begin
      bus.mem_rdata = 32'hA5A5_0000 | DW'(ncount);
    end
  end

  always @(negedge clka) begin : sb_monitor
    sb_t e;
    if (bus.if_valid !== 1'b1) check("if_rdata_idle", bus.if_rdata, '0);
    if (bus.d_valid  !== 1'b1) check("d_rdata_idle", bus.d_rdata, '0);
    if (bus.if_valid === 1'b1 || bus.d_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got valid if=%b d=%b expected none", bus.if_valid, bus.d_valid);
      end else begin
        e = sb_q.pop_front();
        check("sb_side", {bus.d_valid, bus.if_valid}, e.is_d ? 2'b10 : 2'b01);
        check("sb_rdata", e.is_d ? bus.d_rdata : bus.if_rdata, e.rdata);
      end
    end
  end

  task automatic run_one(input vec_t v);
    int k;
    bit got;
    next_cycle();
    if (v.is_d) drive_d(1'b1, v.we, v.addr, v.wdata);
    else        drive_i(1'b1, v.addr);
    sb_push(v.is_d, v.rdata);
    @(negedge clka);
    check("stall_c0", v.is_d ? bus.stall_m : bus.stall_f, 1'b1);
    check("mem_en_c0", bus.mem_en, 1'b0);
    next_cycle();
    @(negedge clka);
    check("mem_en_c1", bus.mem_en, 1'b1);
    check("mem_addr_c1", bus.mem_addr, v.addr);
    check("mem_we_c1", bus.mem_we, v.we);
    check("mem_wdata_c1", bus.mem_wdata, v.we ? v.wdata : '0);
    k   = 1;
    got = 1'b0;
    while (!got && k < 20) begin
      next_cycle();
      k++;
      @(negedge clka);
      got = v.is_d ? bus.d_valid : bus.if_valid;
    end
    check("latency", k, 1 + MEM_LAT);
    check("mem_addr_hold", bus.mem_addr, v.addr);
    check("stall_at_valid", v.is_d ? bus.stall_m : bus.stall_f, 1'b0);
    next_cycle();
    if (v.is_d) bus.d_req = 1'b0;
    else        bus.if_req = 1'b0;
    @(negedge clka);
    check("mem_en_after", bus.mem_en, 1'b0);
  endtask

  vec_t           vecs[7];
  logic [AW-1:0]  first_addr, second_addr;
  logic [1:0]     first_v, second_v;
  bit             first_is_d;
  bit             exp_en[7];

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = '0;
    mem_model[8'h10] = 32'h24020005;
    mem_model[8'h11] = 32'h00851020;
    mem_model[8'h80] = 32'hCAFEF00D;
    mem_model[8'hFF] = 32'h0BADC0DE;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0000_0000, 32'h24020005};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEADBEEF, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0100, 32'hFFFF_FFFF, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0044, 32'h1111_1111, 32'h00851020};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0104, 32'h12345678, 32'h0000_0000};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h7777_7777, 32'h0BADC0DE};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0000_0000, 32'h12345678};
    exp_en = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset with both requests pending, then contention out of reset.
    bus.mem_rdata = '0;
    drive_i(1'b1, 32'h40);
    drive_d(1'b1, 1'b0, 32'h200, 32'h3333_3333);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      @(negedge clka);
      check_all_zero("reset");
    end
`ifdef MEM_ARB_RR_EN
    first_is_d = 1'b0;
`else
    first_is_d = 1'b1;
`endif
    first_addr  = first_is_d ? 32'h200 : 32'h40;
    second_addr = first_is_d ? 32'h40 : 32'h200;
    first_v     = first_is_d ? 2'b10 : 2'b01;
    second_v    = first_is_d ? 2'b01 : 2'b10;
    sb_push(first_is_d, first_is_d ? 32'hCAFEF00D : 32'h24020005);
    sb_push(!first_is_d, first_is_d ? 32'h24020005 : 32'hCAFEF00D);
    next_cycle();
    rst = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) next_cycle();
      if (c == 4) begin
        if (first_is_d) bus.d_req = 1'b0;
        else            bus.if_req = 1'b0;
      end
      @(negedge clka);
      check("rst_arb_en", bus.mem_en, exp_en[c]);
      check("rst_arb_valid", {bus.d_valid, bus.if_valid},
            (c == 3) ? first_v : ((c == 6) ? second_v : 2'b00));
      if (c == 1) check("rst_arb_addr1", bus.mem_addr, first_addr);
      if (c == 4) check("rst_arb_addr2", bus.mem_addr, second_addr);
    end
    next_cycle();
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    @(negedge clka);
    check("rst_arb_idle", bus.mem_en, 1'b0);

    for (int i = 0; i < 7; i++) run_one(vecs[i]);

    // Flush: fetch request withdrawn mid-access still completes.
    next_cycle();
    drive_i(1'b1, 32'h40);
    sb_push(1'b0, 32'h24020005);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next_cycle();
      if (c == 2) bus.if_req = 1'b0;
      @(negedge clka);
      check("flush_en", bus.mem_en, exp_en[c] && (c < 4));
      check("flush_valid", bus.if_valid, c == 3);
      if (c == 2) check("flush_stall", bus.stall_f, 1'b0);
    end

    // Contention after a fetch grant: data first, fetch back-to-back.
    next_cycle();
    drive_d(1'b1, 1'b1, 32'h108, 32'h55AA55AA);
    drive_i(1'b1, 32'h44);
    sb_push(1'b1, 32'h0);
    sb_push(1'b0, 32'h00851020);
    for (int c = 0; c < 7; c++) begin
      if (c > 0) next_cycle();
      if (c == 4) bus.d_req = 1'b0;
      @(negedge clka);
      check("cont_en", bus.mem_en, exp_en[c]);
      check("cont_valid", {bus.d_valid, bus.if_valid},
            (c == 3) ? 2'b10 : ((c == 6) ? 2'b01 : 2'b00));
      if (c == 1) check("cont_cmd1", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 32'h108, 32'h55AA55AA});
      if (c == 4) check("cont_cmd2", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b0, 32'h44, 32'h0});
      if (c == 5) check("cont_stall", {bus.stall_f, bus.stall_m}, 2'b10);
    end
    next_cycle();
    bus.if_req = 1'b0;
    @(negedge clka);
    check("cont_idle", bus.mem_en, 1'b0);

    // Reset during a load: the in-flight response must be discarded.
    next_cycle();
    drive_d(1'b1, 1'b0, 32'h200, 32'h0);
    next_cycle();
    @(negedge clka);
    check("rmid_en_c1", bus.mem_en, 1'b1);
    next_cycle();
    rst = 1'b0;
    @(negedge clka);
    check("rmid_valid_c2", bus.d_valid, 1'b0);
    next_cycle();
    @(negedge clka);
    check_all_zero("rmid_c3");
    check("rmid_rdata_c3", bus.d_rdata, '0);
    next_cycle();
    rst = 1'b1;
    bus.d_req = 1'b0;
    @(negedge clka);
    check("rmid_en_c4", bus.mem_en, 1'b0);
    next_cycle();
    @(negedge clka);
    check("rmid_en_c5", bus.mem_en, 1'b0);

    check("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
